// File: rtl/color_pipe.sv
// Two-stage pixel colour generator: prioritised rectangles, writable palette and a frame-counted flash FSM.
// Optional dashed centre net is built only when COLOR_PIPE_NET_EN is defined.
module color_pipe #(
    parameter int NUM_OBJ      = 3,
    parameter int COORD_W      = 10,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Pixel_valid_in,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    input  logic                         Frame_start,
    input  logic [NUM_OBJ*COORD_W-1:0]   Obj_X,
    input  logic [NUM_OBJ*COORD_W-1:0]   Obj_Y,
    input  logic [NUM_OBJ*COORD_W-1:0]   Obj_HW,
    input  logic [NUM_OBJ*COORD_W-1:0]   Obj_HH,
    input  logic [NUM_OBJ-1:0]           Obj_en,
    input  logic                         Pal_we,
    input  logic [7:0]                   Pal_addr,
    input  logic [23:0]                  Pal_data,
    input  logic                         Flash_req,
    output logic [7:0]                   Red,
    output logic [7:0]                   Green,
    output logic [7:0]                   Blue,
    output logic                         Pixel_valid_out,
    output logic                         Flash_busy
);

    localparam int PAL_N  = NUM_OBJ + 2;
    localparam int BG_IDX = NUM_OBJ;
    localparam int FL_IDX = NUM_OBJ + 1;
    localparam int CW1    = COORD_W + 1;
    localparam logic [CW1-1:0] H_LIM     = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] V_LIM     = CW1'(V_ACTIVE);
    localparam logic [7:0]     CNT_START = 8'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2
    } flash_state_t;

    // Span test in COORD_W+1 bits so neither edge can wrap; low edge clamps at 0.
    function automatic logic in_span(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] hw,
                                     input logic [COORD_W-1:0] d);
        logic [CW1-1:0] lo;
        logic [CW1-1:0] hi;
        lo = (hw > c) ? '0 : ({1'b0, c} - {1'b0, hw});
        hi = {1'b0, c} + {1'b0, hw};
        return ({1'b0, d} >= lo) && ({1'b0, d} <= hi);
    endfunction

    flash_state_t        flash_state_q, flash_state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                busy_q, busy_d;
    logic [23:0]         pal_q [PAL_N];
    logic [23:0]         pal_d [PAL_N];
    logic [NUM_OBJ-1:0]  hit1_q, hit1_d;
    logic                off1_q, off1_d;
    logic                valid1_q, valid1_d;
    logic                net1_q, net1_d;
    logic [23:0]         rgb_q, rgb_d;
    logic                valid2_q, valid2_d;

    always_comb begin
        hit1_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit1_d[i] = Obj_en[i]
                && in_span(Obj_X[i*COORD_W +: COORD_W], Obj_HW[i*COORD_W +: COORD_W], DrawX)
                && in_span(Obj_Y[i*COORD_W +: COORD_W], Obj_HH[i*COORD_W +: COORD_W], DrawY);
        end
        off1_d   = ({1'b0, DrawX} >= H_LIM) || ({1'b0, DrawY} >= V_LIM);
        valid1_d = Pixel_valid_in;
`ifdef COLOR_PIPE_NET_EN
        net1_d = ((DrawX == COORD_W'(H_ACTIVE/2 - 1)) || (DrawX == COORD_W'(H_ACTIVE/2)))
                 && !DrawY[4];
`else
        net1_d = 1'b0;
`endif
    end

    // Later (lower-index) assignments override earlier ones, so index 0 wins.
    always_comb begin
        rgb_d    = '0;
        valid2_d = valid1_q;
        if (valid1_q && !off1_q) begin
            rgb_d = phase_q ? pal_q[FL_IDX] : pal_q[BG_IDX];
            if (net1_q) begin
                rgb_d = pal_q[0];
            end
            for (int i = NUM_OBJ - 1; i >= 0; i--) begin
                if (hit1_q[i]) begin
                    rgb_d = pal_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PAL_N; i++) begin
            pal_d[i] = pal_q[i];
            if (Pal_we && (Pal_addr == 8'(i))) begin
                pal_d[i] = Pal_data;
            end
        end
    end

    always_comb begin
        flash_state_d = flash_state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        case (flash_state_q)
            S_IDLE: begin
                if (Flash_req && Frame_start) begin
                    flash_state_d = S_ACTIVE;
                    cnt_d         = CNT_START;
                    phase_d       = 1'b1;
                end else if (Flash_req) begin
                    flash_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Frame_start) begin
                    flash_state_d = S_ACTIVE;
                    cnt_d         = CNT_START;
                    phase_d       = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (Flash_req && Frame_start) begin
                    cnt_d   = CNT_START;
                    phase_d = 1'b1;
                end else if (Flash_req) begin
                    flash_state_d = S_WAIT;
                    phase_d       = 1'b0;
                end else if (Frame_start) begin
                    if (cnt_q == 8'd0) begin
                        flash_state_d = S_IDLE;
                        phase_d       = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        phase_d = ~phase_q;
                    end
                end
            end
            default: begin
                flash_state_d = S_IDLE;
                phase_d       = 1'b0;
            end
        endcase
        busy_d = (flash_state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_state_q <= S_IDLE;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < PAL_N; i++) begin
                if (i == BG_IDX)      pal_q[i] <= 24'h00007F;
                else if (i == FL_IDX) pal_q[i] <= 24'hFFFF00;
                else                  pal_q[i] <= 24'hFFFFFF;
            end
            hit1_q   <= '0;
            off1_q   <= 1'b0;
            valid1_q <= 1'b0;
            net1_q   <= 1'b0;
            rgb_q    <= '0;
            valid2_q <= 1'b0;
        end else begin
            flash_state_q <= flash_state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            busy_q        <= busy_d;
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= pal_d[i];
            end
            hit1_q   <= hit1_d;
            off1_q   <= off1_d;
            valid1_q <= valid1_d;
            net1_q   <= net1_d;
            rgb_q    <= rgb_d;
            valid2_q <= valid2_d;
        end
    end

    assign Red             = rgb_q[23:16];
    assign Green           = rgb_q[15:8];
    assign Blue            = rgb_q[7:0];
    assign Pixel_valid_out = valid2_q;
    assign Flash_busy      = busy_q;

endmodule
